ucaspian_synapse_fanout: RTL and testbench
==========================================

// Module: ucaspian_synapse_fanout
// PURPOSE
// - Transmit side of the synapse->dendrite interface. Accepts one fire event per spiking neuron,
//   walks that neuron's contiguous synapse range in a local synapse RAM, and emits one
//   (dend_addr, dend_charge) beat per synapse on a valid/ready channel into the dendrite.
// - Sits between the neuron block (fire source) and the dendrite (charge accumulator).
// PARAMETERS
// - SYN_DEPTH    1024  synapse RAM entries; must be a power of 2
// - SYN_AW       10    synapse pointer width, $clog2(SYN_DEPTH)
// - CNT_W        8     fan-out count width; 0..255 synapses per neuron
// PORTS
// - clk           in   1        single clock
// - reset_n       in   1        asynchronous, active-low reset
// - clear_config  in   1        level; zero the entire synapse RAM
// - clear_done    out  1        one-cycle pulse when the clear completes
// - cfg_addr      in   SYN_AW   synapse RAM write address
// - cfg_data      in   16       {target[15:8], weight[7:0] signed}
// - cfg_wr_en     in   1        write strobe; honoured only in IDLE, ignored otherwise
// - fire_ptr      in   SYN_AW   first synapse of the fired neuron
// - fire_cnt      in   CNT_W    number of synapses
// - fire_vld      in   1        fire event valid
// - fire_rdy      out  1        accept; high only in IDLE with no clear pending
// - dend_addr     out  8        target dendrite (neuron) index
// - dend_charge   out  9 s      sign-extended weight
// - dend_vld      out  1        beat valid
// - dend_rdy      in   1        dendrite ready
// - next_step     in   1        timestep boundary pulse
// - step_done     out  1        no fire in progress, out queue empty, no fire_vld pending
// BEHAVIOUR
// - Reset (reset_n=0): all outputs 0; FSM in IDLE; out queue empty; RAM contents undefined.
// - Handshake: a beat transfers on dend_vld&&dend_rdy. While dend_vld=1 and dend_rdy=0,
//   dend_addr and dend_charge hold stable. dend_vld never drops without a transfer.
// - The fire event transfers on fire_vld&&fire_rdy. ptr<=fire_ptr, remain<=fire_cnt.
// - FSM:
//   - IDLE: clear_config -> CLEAR. Otherwise fire accepted with cnt!=0 -> FETCH.
//     A fire with cnt==0 is accepted, emits nothing, and stays in IDLE.
//   - FETCH: issue one RAM read per cycle while queue credits allow (queue 2 entries
//     minus reads in flight). Each read does ptr<=ptr+1 modulo SYN_DEPTH, so the range wraps
//     past the top of the RAM. Read of the last synapse issued -> DRAIN.
//   - DRAIN: wait for the out queue to empty and for no reads in flight -> IDLE.
//   - CLEAR: write 0 at ptr=0..SYN_DEPTH-1, one entry per cycle. Then pulse clear_done -> IDLE.
//     clear_config high in FETCH/DRAIN is deferred until IDLE. Reaching IDLE with it still
//     high re-enters CLEAR.
// - Latency: RAM read data valid 1 cycle after rd_en. Timing with dend_rdy=1:
//   - first dend_vld 2 cycles after fire acceptance;
//   - after that, 1 beat per cycle;
//   - N synapses take N+2 cycles from acceptance to return to IDLE.
// - Output queue: 2-entry FIFO. No read is issued without a guaranteed slot, so full-queue
//   overflow is impossible. Empty queue -> dend_vld=0.
// - Arithmetic: dend_charge = {weight[7], weight[7:0]}; dend_addr = target.
//   Weight 0 synapses are still emitted.
// - step_done: registered. Forced 0 in the cycle after next_step.
//   Otherwise = (state==IDLE) && queue empty && !fire_vld.
// - Simultaneous events: cfg_wr_en with fire acceptance in IDLE -> write takes effect;
//   the fire's reads start next cycle and see the new data. next_step has no effect on
//   an in-progress fire.
// - Reset mid-fire: async clear of all state and outputs; partially emitted beats are lost.
// STRUCTURE
// - Shared package ucaspian_pkg: synapse word struct syn_word_t {logic [7:0] target;
//   logic signed [7:0] weight;}, and localparams DEND_ADDR_W=8, DEND_CHARGE_W=9.
// - Synapse storage: one dp_ram instance, width 16, depth SYN_DEPTH.
// - Natural sub-module: ucaspian_skid_fifo2, the 2-entry valid/ready output queue with
//   credit output.
// TESTING
// - Reset: reset_n=0 for 3 cycles mid-FETCH -> dend_vld=0, fire_rdy=0 during reset,
//   fire_rdy=1 the cycle after release.
// - Basic fan-out: RAM[5..7]={(3,+4),(9,-2),(200,127)}; fire ptr=5 cnt=3, dend_rdy=1 ->
//   beats (3,+4), (9,0x1FE), (200,127) on consecutive cycles starting 2 cycles after
//   acceptance.
// - Backpressure: same fire; dend_rdy toggled 0/1 at random ->
//   - exactly 3 beats, in order;
//   - outputs stable while stalled;
//   - no beat lost or duplicated.
// - Wrap and zero count: fire ptr=1022 cnt=4 -> beats from RAM[1022], [1023], [0], [1].
//   fire cnt=0 -> no beats, fire_rdy=1 next cycle.
// - Clear: write nonzero data, assert clear_config -> clear_done pulses after 1024
//   writes. Fire ptr=0 cnt=2 afterwards -> beats (0,0), (0,0).
// - step_done: next_step pulse while idle -> step_done=0 for 1 cycle, then 1. During a
//   fire, step_done=0 until the last beat transfers and the FSM reaches IDLE.

Source files
------------

// File: rtl/ucaspian_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucaspian_pkg
// Purpose  : Shared types and constants for the uCaspian synapse fan-out path.
//            Holds the synapse RAM word layout, dendrite interface widths,
//            the fan-out FSM state encoding and the weight-to-charge helper.
// Revision : 1.0  initial release
// ============================================================================
package ucaspian_pkg;

    localparam int DEND_ADDR_W   = 8;
    localparam int DEND_CHARGE_W = 9;
    localparam int SYN_W         = 16;

    // Packed so that target occupies bits [15:8] and weight bits [7:0].
    typedef struct packed {
        logic [7:0]        target;
        logic signed [7:0] weight;
    } syn_word_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    // Sign-extend the 8-bit weight into the 9-bit dendrite charge.
    function automatic logic [DEND_CHARGE_W-1:0] charge_of(input syn_word_t w);
        return {w.weight[7], w.weight};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read
//            port. Read data is valid one cycle after i_re. Contents are not
//            reset.
// Ports    : clk            clock
//            i_we/i_waddr/i_wdata   write port
//            i_re/i_raddr           read request
//            o_rdata                read data (registered)
// Revision : 1.0  initial release
// ============================================================================
module dp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ucaspian_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : ucaspian_skid_fifo2
// Purpose  : Two-entry valid/ready output queue. Push has no ready because
//            the producer only issues work it already holds a slot for, using
//            o_count as its credit indication.
// Ports    : clk, i_rst_n   clock, async active-low reset
//            i_push/i_data  enqueue
//            o_vld/i_rdy/o_data   dequeue handshake (head held while stalled)
//            o_count        occupancy 0..2
// Revision : 1.0  initial release
// ============================================================================
module ucaspian_skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop = (r_count != 2'd0) && i_rdy;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem0   <= '0;
            r_mem1   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                if (r_wr_sel) begin
                    r_mem1 <= i_data;
                end else begin
                    r_mem0 <= i_data;
                end
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_rd_sel <= ~r_rd_sel;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_vld   = (r_count != 2'd0);
    assign o_data  = r_rd_sel ? r_mem1 : r_mem0;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ucaspian_synapse_fanout.sv
`default_nettype none
// ============================================================================
// Module   : ucaspian_synapse_fanout
// Purpose  : Transmit side of the synapse->dendrite interface. Accepts one fire
//            event per spiking neuron, walks its contiguous synapse range in
//            the local synapse RAM (wrapping at the top) and emits one
//            (dend_addr, dend_charge) beat per synapse on a valid/ready channel.
// Ports    : clk, reset_n                 clock, async active-low reset
//            clear_config / clear_done    zero whole RAM / completion pulse
//            cfg_addr/cfg_data/cfg_wr_en  RAM write (honoured in IDLE only)
//            fire_ptr/fire_cnt/fire_vld/fire_rdy   fire event handshake
//            dend_addr/dend_charge/dend_vld/dend_rdy  dendrite beat channel
//            next_step / step_done        timestep boundary / idle status
// Revision : 1.0  initial release
// ============================================================================
module ucaspian_synapse_fanout
    import ucaspian_pkg::*;
#(
    parameter int SYN_DEPTH = 1024,
    parameter int SYN_AW    = $clog2(SYN_DEPTH),
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_config,
    output logic                     clear_done,
    input  logic [SYN_AW-1:0]        cfg_addr,
    input  logic [SYN_W-1:0]         cfg_data,
    input  logic                     cfg_wr_en,
    input  logic [SYN_AW-1:0]        fire_ptr,
    input  logic [CNT_W-1:0]         fire_cnt,
    input  logic                     fire_vld,
    output logic                     fire_rdy,
    output logic [DEND_ADDR_W-1:0]   dend_addr,
    output logic [DEND_CHARGE_W-1:0] dend_charge,
    output logic                     dend_vld,
    input  logic                     dend_rdy,
    input  logic                     next_step,
    output logic                     step_done
);

    localparam logic [SYN_AW-1:0] c_PTR_LAST = SYN_AW'(SYN_DEPTH - 1);
    localparam logic [SYN_AW-1:0] c_PTR_ONE  = SYN_AW'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [SYN_AW-1:0] r_ptr;
    logic [CNT_W-1:0]  r_remain;
    logic              r_inflight;   // a RAM read issued last cycle lands now
    logic              r_active;     // holds fire_rdy low until first clock after reset
    logic              r_step_done;
    logic              r_clear_done;

    logic              w_rd_en;
    logic              w_ram_we;
    logic [SYN_AW-1:0] w_ram_waddr;
    logic [SYN_W-1:0]  w_ram_wdata;
    logic [SYN_W-1:0]  w_rd_data;
    logic              w_fire_rdy;
    logic              w_fire_acc;
    logic              w_pop;
    logic              w_can_read;
    logic              w_q_vld;
    logic [SYN_W-1:0]  w_q_data;
    logic [1:0]        w_q_count;
    syn_word_t         w_head;

    assign w_fire_acc = fire_vld && w_fire_rdy;
    assign w_pop      = w_q_vld && dend_rdy;

    // A read may issue only if a queue slot is guaranteed when its data lands:
    // occupancy plus the read already in flight, minus the beat leaving now.
    assign w_can_read = ({1'b0, w_q_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clear_config) begin
                    w_next_state = ST_CLEAR;
                end else if (w_fire_acc && (fire_cnt != '0)) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_rd_en && (r_remain == c_CNT_ONE)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the last beat transfers so N synapses take N+2 cycles.
                if (!r_inflight && ((w_q_count == 2'd0) || ((w_q_count == 2'd1) && w_pop))) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_ptr == c_PTR_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        w_rd_en     = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = cfg_addr;
        w_ram_wdata = cfg_data;
        w_fire_rdy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_fire_rdy = r_active && !clear_config;
                w_ram_we   = cfg_wr_en;
            end
            ST_FETCH: begin
                w_rd_en = w_can_read;
            end
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_ptr;
                w_ram_wdata = '0;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_remain     <= '0;
            r_inflight   <= 1'b0;
            r_active     <= 1'b0;
            r_step_done  <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_active     <= 1'b1;
            r_inflight   <= w_rd_en;
            r_clear_done <= (r_state == ST_CLEAR) && (r_ptr == c_PTR_LAST);
            r_step_done  <= !next_step && (r_state == ST_IDLE) &&
                            (w_q_count == 2'd0) && !fire_vld;
            case (r_state)
                ST_IDLE: begin
                    if (clear_config) begin
                        r_ptr <= '0;
                    end else if (w_fire_acc) begin
                        r_ptr    <= fire_ptr;
                        r_remain <= fire_cnt;
                    end
                end
                ST_FETCH: begin
                    if (w_rd_en) begin
                        r_ptr    <= r_ptr + c_PTR_ONE;   // wraps modulo SYN_DEPTH
                        r_remain <= r_remain - c_CNT_ONE;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + c_PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    // ---------------- storage and output queue ----------------
    dp_ram #(
        .WIDTH (SYN_W),
        .DEPTH (SYN_DEPTH),
        .AW    (SYN_AW)
    ) u_syn_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_rd_en),
        .i_raddr (r_ptr),
        .o_rdata (w_rd_data)
    );

    ucaspian_skid_fifo2 #(
        .WIDTH (SYN_W)
    ) u_out_q (
        .clk     (clk),
        .i_rst_n (reset_n),
        .i_push  (r_inflight),
        .i_data  (w_rd_data),
        .o_vld   (w_q_vld),
        .i_rdy   (dend_rdy),
        .o_data  (w_q_data),
        .o_count (w_q_count)
    );

    assign w_head      = w_q_data;
    assign dend_vld    = w_q_vld;
    assign dend_addr   = w_head.target;
    assign dend_charge = charge_of(w_head);
    assign fire_rdy    = w_fire_rdy;
    assign step_done   = r_step_done;
    assign clear_done  = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_ucaspian_synapse_fanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucaspian_synapse_fanout
// Purpose  : Self-checking bench for ucaspian_synapse_fanout. Expected beats
//            come from a behavioural RAM image and the synapse-to-charge rule.
// Revision : 1.0  initial release
// ============================================================================
module tb_ucaspian_synapse_fanout;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_config;
    logic        clear_done;
    logic [9:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_wr_en;
    logic [9:0]  fire_ptr;
    logic [7:0]  fire_cnt;
    logic        fire_vld;
    logic        fire_rdy;
    logic [7:0]  dend_addr;
    logic [8:0]  dend_charge;
    logic        dend_vld;
    logic        dend_rdy;
    logic        next_step;
    logic        step_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ram [1024];

    logic [16:0] got_q[$];
    int          got_idx[$];
    int          idle_idx;
    int          stall_viol;
    int          extra_beats;
    bit          timed_out;
    logic        sd_hist [0:511];

    always #5 clk = ~clk;

    ucaspian_synapse_fanout dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_config (clear_config),
        .clear_done   (clear_done),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_wr_en    (cfg_wr_en),
        .fire_ptr     (fire_ptr),
        .fire_cnt     (fire_cnt),
        .fire_vld     (fire_vld),
        .fire_rdy     (fire_rdy),
        .dend_addr    (dend_addr),
        .dend_charge  (dend_charge),
        .dend_vld     (dend_vld),
        .dend_rdy     (dend_rdy),
        .next_step    (next_step),
        .step_done    (step_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference: beat for synapse address a, {target, sign-extended weight}.
    function automatic logic [16:0] exp_beat(input int a);
        logic [15:0] w;
        int          wt;
        w  = m_ram[a % 1024];
        wt = int'(w[7:0]);
        if (wt >= 128) wt = wt - 256;
        return {w[15:8], 9'(wt)};
    endfunction

    task automatic cfg_write(input logic [9:0] a, input logic [15:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_wr_en = 1'b1;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        m_ram[a]  = d;
    endtask

    // Called at posedge+1; returns at acceptance edge +1.
    task automatic do_fire(input logic [9:0] p, input logic [7:0] c, output bit acc);
        acc      = 1'b0;
        fire_ptr = p;
        fire_cnt = c;
        fire_vld = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (fire_rdy) acc = 1'b1;
            @(posedge clk); #1;
        end
        fire_vld = 1'b0;
    endtask

    // Records beats (sampled at negedge, index 0 = first cycle after acceptance).
    task automatic collect(input int exp_n, input bit rnd);
        logic [16:0] prev;
        bit          stalled;
        bit          done;
        int          last_i;
        got_q.delete();
        got_idx.delete();
        idle_idx    = -1;
        stall_viol  = 0;
        extra_beats = 0;
        stalled     = 1'b0;
        done        = 1'b0;
        prev        = '0;
        last_i      = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            sd_hist[i] = step_done;
            if (dend_vld) begin
                if (stalled && ({dend_addr, dend_charge} !== prev)) stall_viol++;
                if (dend_rdy) begin
                    got_q.push_back({dend_addr, dend_charge});
                    got_idx.push_back(i);
                end
                stalled = !dend_rdy;
                prev    = {dend_addr, dend_charge};
            end else begin
                if (stalled) stall_viol++;
                stalled = 1'b0;
            end
            if (fire_rdy && idle_idx < 0) idle_idx = i;
            last_i = i;
            @(posedge clk); #1;
            if (got_q.size() >= exp_n && idle_idx >= 0) done = 1'b1;
            else dend_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        timed_out = !done;
        dend_rdy  = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            sd_hist[last_i + e] = step_done;
            if (dend_vld) extra_beats++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        clear_config = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
        cfg_wr_en    = 1'b0;
        fire_ptr     = '0;
        fire_cnt     = '0;
        fire_vld     = 1'b0;
        dend_rdy     = 1'b1;
        next_step    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dend_vld, fire_rdy, step_done, clear_done} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs vld/rdy/sd/cd got %b want 0000", {dend_vld, fire_rdy, step_done, clear_done});
            end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (fire_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_fire_rdy got %b want 1", fire_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        int cd_idx;
        int cd_cnt;
        bit acc;
        cfg_write(10'd0, 16'h1234);
        cfg_write(10'd1, 16'hABCD);
        cfg_write(10'd1023, 16'h7F7F);
        clear_config = 1'b1;
        cd_idx = -1;
        cd_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (clear_done) begin
                cd_cnt++;
                if (cd_idx < 0) cd_idx = i;
            end
            @(posedge clk); #1;
            clear_config = 1'b0;
        end
        checks++;
        if (cd_idx !== 1025) begin
            errors++;
            $display("FAIL clear_done_time got %0d want 1025", cd_idx);
        end
        checks++;
        if (cd_cnt !== 1) begin
            errors++;
            $display("FAIL clear_done_pulse_width got %0d want 1", cd_cnt);
        end
        for (int a = 0; a < 1024; a++) m_ram[a] = 16'h0000;
        dend_rdy = 1'b1;
        do_fire(10'd0, 8'd2, acc);
        collect(2, 1'b0);
        checks++;
        if (!acc || timed_out || got_q.size() != 2) begin
            errors++;
            $display("FAIL clear_fire_beats got %0d beats acc=%0d to=%0d want 2", got_q.size(), acc, timed_out);
        end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== 17'h0) begin
                errors++;
                $display("FAIL clear_beat%0d got %h want 00000", i, got_q[i]);
            end
        end
    endtask

    task automatic test_basic;
        bit          acc;
        logic [16:0] want [3];
        want[0] = {8'd3, 9'h004};
        want[1] = {8'd9, 9'h1FE};
        want[2] = {8'd200, 9'h07F};
        cfg_write(10'd5, 16'h0304);
        cfg_write(10'd6, 16'h09FE);
        cfg_write(10'd7, 16'hC87F);
        dend_rdy = 1'b1;
        do_fire(10'd5, 8'd3, acc);
        collect(3, 1'b0);
        checks++;
        if (!acc || timed_out || got_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count got %0d acc=%0d to=%0d want 3", got_q.size(), acc, timed_out);
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i] || got_idx[i] != i + 2) begin
                errors++;
                $display("FAIL basic_beat%0d got %h@%0d want %h@%0d", i, got_q[i], got_idx[i], want[i], i + 2);
            end
        end
        checks++;
        if (idle_idx != 5) begin
            errors++;
            $display("FAIL basic_idle_latency got %0d want 5", idle_idx);
        end
    endtask

    task automatic test_backpressure;
        bit acc;
        for (int r = 0; r < 4; r++) begin
            dend_rdy = 1'($urandom_range(0, 1));
            do_fire(10'd5, 8'd3, acc);
            collect(3, 1'b1);
            checks++;
            if (!acc || timed_out || got_q.size() != 3 || extra_beats != 0) begin
                errors++;
                $display("FAIL bp_count run%0d got %0d extra %0d to=%0d want 3", r, got_q.size(), extra_beats, timed_out);
            end
            checks++;
            if (stall_viol != 0) begin
                errors++;
                $display("FAIL bp_stable run%0d got %0d violations want 0", r, stall_viol);
            end
            for (int i = 0; i < got_q.size() && i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_beat(5 + i)) begin
                    errors++;
                    $display("FAIL bp_beat run%0d #%0d got %h want %h", r, i, got_q[i], exp_beat(5 + i));
                end
            end
        end
    endtask

    task automatic test_wrap_zero;
        bit acc;
        cfg_write(10'd1022, 16'($urandom));
        cfg_write(10'd1023, 16'($urandom));
        cfg_write(10'd0, 16'($urandom));
        cfg_write(10'd1, 16'($urandom));
        dend_rdy = 1'b1;
        do_fire(10'd1022, 8'd4, acc);
        collect(4, 1'b0);
        checks++;
        if (!acc || timed_out || got_q.size() != 4) begin
            errors++;
            $display("FAIL wrap_count got %0d to=%0d want 4", got_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++;
            if (got_q[i] !== exp_beat(1022 + i)) begin
                errors++;
                $display("FAIL wrap_beat%0d got %h want %h", i, got_q[i], exp_beat(1022 + i));
            end
        end
        do_fire(10'd300, 8'd0, acc);
        collect(0, 1'b0);
        checks++;
        if (!acc || got_q.size() != 0 || extra_beats != 0 || idle_idx != 0) begin
            errors++;
            $display("FAIL zero_count beats %0d extra %0d idle_idx %0d want 0 0 0", got_q.size(), extra_beats, idle_idx);
        end
    endtask

    task automatic test_step_done;
        bit acc;
        dend_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (step_done !== 1'b1) begin
            errors++;
            $display("FAIL step_done_idle got %b want 1", step_done);
        end
        @(posedge clk); #1;
        next_step = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        next_step = 1'b0;
        @(negedge clk);
        checks++;
        if (step_done !== 1'b0) begin
            errors++;
            $display("FAIL step_done_after_next got %b want 0", step_done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (step_done !== 1'b1) begin
            errors++;
            $display("FAIL step_done_recover got %b want 1", step_done);
        end
        @(posedge clk); #1;
        do_fire(10'd5, 8'd3, acc);
        collect(3, 1'b0);
        for (int i = 0; i <= idle_idx && i < 400; i++) begin
            checks++;
            if (sd_hist[i] !== 1'b0) begin
                errors++;
                $display("FAIL step_done_busy idx%0d got %b want 0", i, sd_hist[i]);
            end
        end
        checks++;
        if (idle_idx < 0 || sd_hist[idle_idx + 1] !== 1'b1) begin
            errors++;
            $display("FAIL step_done_end idle_idx %0d want step_done=1 after idle", idle_idx);
        end
    endtask

    task automatic test_random;
        bit          acc;
        int          p;
        int          c;
        for (int k = 0; k < 40; k++) cfg_write(10'($urandom), 16'($urandom));
        for (int r = 0; r < 8; r++) begin
            p = int'($urandom_range(0, 1023));
            c = int'($urandom_range(0, 12));
            dend_rdy = 1'($urandom_range(0, 1));
            do_fire(10'(p), 8'(c), acc);
            collect(c, 1'b1);
            checks++;
            if (!acc || timed_out || got_q.size() != c || extra_beats != 0 || stall_viol != 0) begin
                errors++;
                $display("FAIL rand_run%0d beats %0d want %0d extra %0d stall %0d to=%0d", r, got_q.size(), c, extra_beats, stall_viol, timed_out);
            end
            for (int i = 0; i < got_q.size() && i < c; i++) begin
                checks++;
                if (got_q[i] !== exp_beat(p + i)) begin
                    errors++;
                    $display("FAIL rand_run%0d beat%0d got %h want %h", r, i, got_q[i], exp_beat(p + i));
                end
            end
        end
    endtask

    task automatic test_reset_midfire;
        bit acc;
        dend_rdy = 1'b0;
        do_fire(10'd5, 8'd3, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        checks++;
        if (dend_vld !== 1'b1) begin
            errors++;
            $display("FAIL midfire_stalled_vld got %b want 1", dend_vld);
        end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dend_vld !== 1'b0 || fire_rdy !== 1'b0) begin
                errors++;
                $display("FAIL midfire_reset vld %b rdy %b want 0 0", dend_vld, fire_rdy);
            end
            @(posedge clk); #1;
        end
        reset_n  = 1'b1;
        dend_rdy = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (fire_rdy !== 1'b1 || dend_vld !== 1'b0) begin
            errors++;
            $display("FAIL midfire_release rdy %b vld %b want 1 0", fire_rdy, dend_vld);
        end
        @(posedge clk); #1;
        do_fire(10'd5, 8'd3, acc);
        collect(3, 1'b0);
        checks++;
        if (!acc || got_q.size() != 3 || got_q[0] !== {8'd3, 9'h004}) begin
            errors++;
            $display("FAIL midfire_refire beats %0d first %h want 3 and 00604", got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_basic();
        test_backpressure();
        test_wrap_zero();
        test_step_done();
        test_random();
        test_reset_midfire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
